// File: rtl/rgen_apb_initiator.sv
// APB4 requester for rgen register blocks: one command at a time from a valid/ready
// port, run as an APB SETUP/ACCESS transfer, result returned on a valid/ready port.
module rgen_apb_initiator #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_command_valid,
  output logic                      o_command_ready,
  input  logic                      i_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [2:0]                i_prot,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_write_strobe,
  output logic                      o_response_valid,
  input  logic                      i_response_ready,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic [1:0]                o_status,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                o_pprot,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);
  // Count value seen during the last permitted ACCESS cycle.
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] ST_OKAY    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESPONSE} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]               pprot_q, pprot_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic                     pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]    pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      paddr_q      <= '0;
      pprot_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rdata_q      <= '0;
      status_q     <= '0;
      resp_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      resp_valid_q <= resp_valid_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    resp_valid_d = resp_valid_q;
    count_d      = count_q;

    case (state_q)
      S_IDLE: begin
        if (i_command_valid) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = i_address;
          pprot_d   = i_prot;
          pwrite_d  = i_write;
          pwdata_d  = i_write ? i_write_data : '0;
          pstrb_d   = i_write ? i_write_strobe : '0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        count_d   = '0;
      end
      S_ACCESS: begin
        // Timeout wins over a PREADY arriving in the final permitted cycle.
        if (TO_EN && (count_q == TO_LAST)) begin
          state_d      = S_RESPONSE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rdata_d      = '0;
          status_d     = ST_TIMEOUT;
          resp_valid_d = 1'b1;
        end else if (i_pready) begin
          state_d      = S_RESPONSE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rdata_d      = pwrite_q ? '0 : i_prdata;
          status_d     = i_pslverr ? 2'b01 : ST_OKAY;
          resp_valid_d = 1'b1;
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      S_RESPONSE: begin
        if (i_response_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_command_ready  = (state_q == S_IDLE) & ~rst;
  assign o_response_valid = resp_valid_q;
  assign o_read_data      = rdata_q;
  assign o_status         = status_q;
  assign o_paddr          = paddr_q;
  assign o_pprot          = pprot_q;
  assign o_psel           = psel_q;
  assign o_penable        = penable_q;
  assign o_pwrite         = pwrite_q;
  assign o_pwdata         = pwdata_q;
  assign o_pstrb          = pstrb_q;

endmodule

// File: tb/tb_rgen_apb_initiator.sv
// Self-checking bench for rgen_apb_initiator: scoreboarded responses plus APB timing checks,
// with a second instance built with a short timeout.
module tb_rgen_apb_initiator;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [2:0]  cmd_prot = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        resp_ready = 1'b1;

  logic        rdy_a, rv_a, psel_a, pen_a, pwr_a;
  logic [31:0] rd_a, pwd_a;
  logic [1:0]  st_a;
  logic [15:0] paddr_a;
  logic [2:0]  pprot_a;
  logic [3:0]  pstrb_a;
  logic        pready_a = 1'b0, pslverr_a = 1'b0;
  logic [31:0] prdata_a = '0;

  logic        rdy_b, rv_b, psel_b, pen_b, pwr_b;
  logic [31:0] rd_b, pwd_b;
  logic [1:0]  st_b;
  logic [15:0] paddr_b;
  logic [2:0]  pprot_b;
  logic [3:0]  pstrb_b;
  logic        pready_b = 1'b0, pslverr_b = 1'b0;
  logic [31:0] prdata_b = '0;

  int          ws_cfg_a = 0, ws_cfg_b = 0, wcnt_a = 0, wcnt_b = 0;
  logic [31:0] rdat_cfg_a = '0, rdat_cfg_b = '0;
  logic        err_cfg_a = 1'b0, err_cfg_b = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic pv_a = 1'b0, pv_b = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  rgen_apb_initiator #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst(rst),
    .i_command_valid(valid_a), .o_command_ready(rdy_a),
    .i_write(cmd_write), .i_address(cmd_addr), .i_prot(cmd_prot),
    .i_write_data(cmd_wdata), .i_write_strobe(cmd_strb),
    .o_response_valid(rv_a), .i_response_ready(resp_ready),
    .o_read_data(rd_a), .o_status(st_a),
    .o_paddr(paddr_a), .o_pprot(pprot_a), .o_psel(psel_a), .o_penable(pen_a),
    .o_pwrite(pwr_a), .o_pwdata(pwd_a), .o_pstrb(pstrb_a),
    .i_pready(pready_a), .i_prdata(prdata_a), .i_pslverr(pslverr_a)
  );

  rgen_apb_initiator #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst),
    .i_command_valid(valid_b), .o_command_ready(rdy_b),
    .i_write(cmd_write), .i_address(cmd_addr), .i_prot(cmd_prot),
    .i_write_data(cmd_wdata), .i_write_strobe(cmd_strb),
    .o_response_valid(rv_b), .i_response_ready(resp_ready),
    .o_read_data(rd_b), .o_status(st_b),
    .o_paddr(paddr_b), .o_pprot(pprot_b), .o_psel(psel_b), .o_penable(pen_b),
    .o_pwrite(pwr_b), .o_pwdata(pwd_b), .o_pstrb(pstrb_b),
    .i_pready(pready_b), .i_prdata(prdata_b), .i_pslverr(pslverr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // APB completers: hold PREADY low for ws_cfg ACCESS cycles, then complete.
  always @(negedge clk) begin
    if (rst || !(psel_a && pen_a)) begin
      pready_a = 1'b0; wcnt_a = 0; prdata_a = '0; pslverr_a = 1'b0;
    end else if (wcnt_a >= ws_cfg_a) begin
      pready_a = 1'b1; prdata_a = rdat_cfg_a; pslverr_a = err_cfg_a;
    end else begin
      pready_a = 1'b0; wcnt_a++;
    end
  end

  always @(negedge clk) begin
    if (rst || !(psel_b && pen_b)) begin
      pready_b = 1'b0; wcnt_b = 0; prdata_b = '0; pslverr_b = 1'b0;
    end else if (wcnt_b >= ws_cfg_b) begin
      pready_b = 1'b1; prdata_b = rdat_cfg_b; pslverr_b = err_cfg_b;
    end else begin
      pready_b = 1'b0; wcnt_b++;
    end
  end

  // Scoreboards: compare each response when its valid first appears.
  always @(negedge clk) begin
    if (rst) pv_a = 1'b0;
    else begin
      if (rv_a && !pv_a) begin
        if (q_a.size() == 0) check_eq("resp_a_unexpected", 64'd1, 64'd0);
        else begin
          e_a = q_a.pop_front();
          check_eq("rdata_a", 64'(rd_a), 64'(e_a.data));
          check_eq("status_a", 64'(st_a), 64'(e_a.st));
        end
      end
      pv_a = rv_a;
    end
  end

  always @(negedge clk) begin
    if (rst) pv_b = 1'b0;
    else begin
      if (rv_b && !pv_b) begin
        if (q_b.size() == 0) check_eq("resp_b_unexpected", 64'd1, 64'd0);
        else begin
          e_b = q_b.pop_front();
          check_eq("rdata_b", 64'(rd_b), 64'(e_b.data));
          check_eq("status_b", 64'(st_b), 64'(e_b.st));
        end
      end
      pv_b = rv_b;
    end
  end

  // Called at a negedge with valid high; returns at the negedge after acceptance.
  task automatic wait_ready(input bit to_b, output int acc);
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (to_b ? rdy_b : rdy_a) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check_eq("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_d, input logic [1:0] exp_s,
                         input bit to_b);
    exp_t e;
    cmd_write = w; cmd_addr = a; cmd_prot = 3'(a[2:0]); cmd_wdata = d; cmd_strb = s;
    e.data = exp_d; e.st = exp_s;
    if (to_b) q_b.push_back(e); else q_a.push_back(e);
  endtask

  task automatic issue(input bit to_b, input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_d, input logic [1:0] exp_s);
    int acc;
    set_cmd(w, a, d, s, exp_d, exp_s, to_b);
    if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
    wait_ready(to_b, acc);
    valid_a = 1'b0; valid_b = 1'b0;
    cmd_addr = 16'hFFFF; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_write = ~w;
  endtask

  // From the SETUP negedge of DUT A: checks SETUP/ACCESS phasing and stability.
  task automatic run_access(input logic w, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int n);
    logic [55:0] exp_bus;
    exp_bus = {a, 3'(a[2:0]), w, (w ? d : 32'h0), (w ? s : 4'h0)};
    check_eq("setup_psel", 64'(psel_a), 64'd1);
    check_eq("setup_penable", 64'(pen_a), 64'd0);
    check_eq("setup_bus", 64'({paddr_a, pprot_a, pwr_a, pwd_a, pstrb_a}), 64'(exp_bus));
    n = 0;
    @(negedge clk);
    check_eq("access_penable", 64'(pen_a), 64'd1);
    while (psel_a && pen_a && n < 40) begin
      check_eq("access_stable", 64'({paddr_a, pprot_a, pwr_a, pwd_a, pstrb_a}), 64'(exp_bus));
      n++;
      @(negedge clk);
    end
    check_eq("end_psel", 64'({psel_a, pen_a}), 64'd0);
    check_eq("resp_valid_on_end", 64'(rv_a), 64'd1);
  endtask

  initial begin
    int n, acc1, acc2;
    @(negedge clk);
    check_eq("rst_outs_a", 64'({rdy_a, rv_a, psel_a, pen_a, pwr_a, paddr_a, pstrb_a, st_a}), 64'd0);
    check_eq("rst_data_a", 64'({rd_a, pwd_a}), 64'd0);
    check_eq("rst_outs_b", 64'({rdy_b, rv_b, psel_b, pen_b}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_idle", 64'(rdy_a), 64'd1);

    // 1: zero-wait write, response at T+3
    ws_cfg_a = 0; err_cfg_a = 0; rdat_cfg_a = 32'h1111_2222;
    issue(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00);
    run_access(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, n);
    check_eq("t1_access_cycles", 64'(n), 64'd1);
    @(negedge clk);

    // 2: read with five wait states
    ws_cfg_a = 5; rdat_cfg_a = 32'h1234_5678;
    issue(0, 1'b0, 16'h0004, 32'hAAAA_AAAA, 4'hF, 32'h1234_5678, 2'b00);
    check_eq("t2_pstrb", 64'(pstrb_a), 64'd0);
    check_eq("t2_pwdata", 64'(pwd_a), 64'd0);
    run_access(1'b0, 16'h0004, 32'h0, 4'h0, n);
    check_eq("t2_access_cycles", 64'(n), 64'd6);
    @(negedge clk);

    // 3: slave error on completion
    ws_cfg_a = 2; rdat_cfg_a = 32'hCAFE_F00D; err_cfg_a = 1;
    issue(0, 1'b0, 16'h0008, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b01);
    run_access(1'b0, 16'h0008, 32'h0, 4'h0, n);
    check_eq("t3_access_cycles", 64'(n), 64'd3);
    err_cfg_a = 0;
    @(negedge clk);

    // 4: timeout on the short-timeout instance, then a normal read
    ws_cfg_b = 1000;
    issue(1, 1'b0, 16'h0040, 32'h0, 4'h0, 32'h0, 2'b10);
    check_eq("t4_setup", 64'({psel_b, pen_b}), 64'b10);
    @(negedge clk);
    n = 0;
    while (psel_b && pen_b && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("t4_access_cycles", 64'(n), 64'd4);
    check_eq("t4_dropped", 64'({psel_b, pen_b, rv_b}), 64'b001);
    @(negedge clk);
    ws_cfg_b = 1; rdat_cfg_b = 32'h55AA_55AA;
    issue(1, 1'b0, 16'h0044, 32'h0, 4'h0, 32'h55AA_55AA, 2'b00);
    repeat (6) @(negedge clk);

    // 5: response backpressure, then back-to-back commands
    resp_ready = 1'b0; ws_cfg_a = 0; rdat_cfg_a = 32'h0BAD_C0DE;
    issue(0, 1'b0, 16'h0020, 32'h0, 4'h0, 32'h0BAD_C0DE, 2'b00);
    run_access(1'b0, 16'h0020, 32'h0, 4'h0, n);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_hold", 64'({rv_a, rd_a, st_a, rdy_a}), 64'({1'b1, 32'h0BAD_C0DE, 2'b00, 1'b0}));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    set_cmd(1'b1, 16'h0030, 32'h0000_0001, 4'h3, 32'h0, 2'b00, 0);
    valid_a = 1'b1;
    wait_ready(0, acc1);
    set_cmd(1'b1, 16'h0034, 32'h0000_0002, 4'hC, 32'h0, 2'b00, 0);
    wait_ready(0, acc2);
    valid_a = 1'b0;
    check_eq("t5_throughput", 64'(acc2 - acc1), 64'd4);
    check_eq("t5_second_addr", 64'({paddr_a, pstrb_a}), 64'({16'h0034, 4'hC}));
    repeat (5) @(negedge clk);

    // 6: reset during ACCESS loses the transfer
    ws_cfg_a = 10; rdat_cfg_a = 32'h7777_7777;
    issue(0, 1'b0, 16'h0050, 32'h0, 4'h0, 32'h7777_7777, 2'b00);
    @(negedge clk);
    check_eq("t6_in_access", 64'({psel_a, pen_a}), 64'b11);
    rst = 1'b1;
    #1;
    check_eq("t6_async_drop", 64'({psel_a, pen_a, rdy_a}), 64'd0);
    q_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_ready_after", 64'(rdy_a), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_no_resp", 64'(rv_a), 64'd0);
    end
    ws_cfg_a = 0; rdat_cfg_a = 32'h0102_0304;
    issue(0, 1'b0, 16'h0060, 32'h0, 4'h0, 32'h0102_0304, 2'b00);
    run_access(1'b0, 16'h0060, 32'h0, 4'h0, n);
    repeat (3) @(negedge clk);

    check_eq("sb_drain_a", 64'(q_a.size()), 64'd0);
    check_eq("sb_drain_b", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
